// File: rtl/sand_level_ctrl_pkg.sv
// Shared hourglass constants, FSM state type and the level-to-row mapping helpers.
package sand_level_ctrl_pkg;

  localparam int ROW_W         = 11;
  localparam int LEVEL_MAX_DEF = 69;
  localparam int LEVEL_W_DEF   = 7;
  localparam int SAND_HALF_H   = 68;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Lower bulb fills upward from its centre row; L=0 places the top one row below the centre.
  function automatic logic [ROW_W-1:0] row_lower(input logic [ROW_W-1:0] ori,
                                                 input logic [ROW_W-1:0] l);
    return ori + ROW_W'(1) - l;
  endfunction

  function automatic logic [ROW_W-1:0] row_upper(input logic [ROW_W-1:0] ori,
                                                 input logic [ROW_W-1:0] l);
    return ori + l;
  endfunction

endpackage

// File: rtl/sand_level_ctrl_frame_step_div.sv
// Frame divider: emits a one-cycle step each STEP_FRAMES enabled frame_start pulses.
module frame_step_div #(
  parameter int STEP_FRAMES = 52
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic enable,
  input  logic clear,
  output logic step
);

  localparam int CW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_FRAMES - 1);

  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == LAST);
  // Combinational so the level can move in the same cycle frame_start is high.
  assign step = enable & frame_start & ~clear & last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (enable && frame_start)
      cnt <= last ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/sand_level_ctrl.sv
// Sand level sequencer: frame-paced level L and the lower/upper bulb fill rows derived from it.
module sand_level_ctrl
  import sand_level_ctrl_pkg::*;
#(
  parameter int STEP_FRAMES = 52,
  parameter int LEVEL_MAX   = LEVEL_MAX_DEF,
  parameter int LEVEL_W     = LEVEL_W_DEF
) (
  input  logic               clk,
  input  logic               BTN_S_n,
  input  logic               start,
  input  logic               pause,
  input  logic               frame_start,
  input  logic [ROW_W-1:0]   ori_row_lo,
  input  logic [ROW_W-1:0]   ori_row_up,
  output logic [ROW_W-1:0]   lower_row,
  output logic [ROW_W-1:0]   upper_row,
  output logic [LEVEL_W-1:0] level,
  output logic               running,
  output logic               done
);

  localparam logic [LEVEL_W-1:0] LAST_LVL = LEVEL_W'(LEVEL_MAX - 1);

  state_e             state;
  logic [LEVEL_W-1:0] lvl;
  logic [LEVEL_W-1:0] lvl_q;
  logic               div_en;
  logic               step;

  assign div_en = (state == ST_RUN) && !start;

  frame_step_div #(.STEP_FRAMES(STEP_FRAMES)) u_div (
    .clk         (clk),
    .rst_n       (BTN_S_n),
    .frame_start (frame_start),
    .enable      (div_en),
    .clear       (start),
    .step        (step)
  );

  // start overrides everything; within RUN the frame is counted before pause is honoured.
  always_ff @(posedge clk or negedge BTN_S_n) begin
    if (!BTN_S_n) begin
      state   <= ST_IDLE;
      lvl     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      state   <= ST_RUN;
      lvl     <= '0;
      running <= 1'b1;
      done    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: ;
        ST_RUN: begin
          if (step) lvl <= lvl + LEVEL_W'(1);
          if (step && lvl == LAST_LVL) begin
            state   <= ST_DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (pause) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (pause) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_DONE: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge BTN_S_n) begin
    if (!BTN_S_n) lvl_q <= '0;
    else          lvl_q <= lvl;
  end

  // Bulb origins are static, so rows built from lvl_q behave as registered outputs
  // while still resetting to the empty/full positions asynchronously.
  assign level     = lvl_q;
  assign lower_row = row_lower(ori_row_lo, ROW_W'(lvl_q));
  assign upper_row = row_upper(ori_row_up, ROW_W'(lvl_q));

endmodule

// File: tb/tb_sand_level_ctrl.sv
// Scoreboard bench: driver pushes model expectations, a negedge monitor pops and compares.
module tb_sand_level_ctrl;

  localparam int STEP = 2;
  localparam int LMAX = 69;
  localparam int LO   = 300;
  localparam int UP   = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, pause = 1'b0, frame_start = 1'b0;
  logic [10:0] ori_lo = 11'(LO), ori_up = 11'(UP);
  logic [10:0] lower_row, upper_row;
  logic [6:0]  level;
  logic        running, done;

  always #5 clk = ~clk;

  sand_level_ctrl #(.STEP_FRAMES(STEP), .LEVEL_MAX(LMAX), .LEVEL_W(7)) dut (
    .clk         (clk),
    .BTN_S_n     (rst_n),
    .start       (start),
    .pause       (pause),
    .frame_start (frame_start),
    .ori_row_lo  (ori_lo),
    .ori_row_up  (ori_up),
    .lower_row   (lower_row),
    .upper_row   (upper_row),
    .level       (level),
    .running     (running),
    .done        (done)
  );

  typedef struct {int lvl; bit run; bit dn;} exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;

  // Reference model: level, frames into current step, and run/pause/done flags.
  int m_l = 0, m_cnt = 0;
  bit m_run = 0, m_pause = 0, m_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic snap(input string name, input int l, input bit r, input bit d);
    chk({name, "_level"}, 32'(level), 32'(l));
    chk({name, "_lower"}, 32'(lower_row), 32'(LO + 1 - l));
    chk({name, "_upper"}, 32'(upper_row), 32'(UP + l));
    chk({name, "_running"}, 32'(running), 32'(r));
    chk({name, "_done"}, 32'(done), 32'(d));
  endtask

  task automatic model_reset();
    m_l = 0; m_cnt = 0; m_run = 0; m_pause = 0; m_done = 0;
  endtask

  // Called at negedge+1; returns at the following negedge+1.
  task automatic cycle(input bit s, input bit p, input bit f);
    exp_t e;
    start = s; pause = p; frame_start = f;
    e.lvl = m_l;  // visible level trails L by one clock
    if (s) begin
      m_l = 0; m_cnt = 0; m_run = 1; m_pause = 0; m_done = 0;
    end else if (m_run) begin
      if (f) begin
        m_cnt++;
        if (m_cnt == STEP) begin
          m_cnt = 0;
          m_l++;
          if (m_l == LMAX) begin m_run = 0; m_done = 1; end
        end
      end
      if (p && !m_done) begin m_run = 0; m_pause = 1; end
    end else if (m_pause) begin
      if (p) begin m_run = 1; m_pause = 0; end
    end
    e.run = m_run;
    e.dn  = m_done;
    q.push_back(e);
    @(negedge clk);
    #1;
    start = 0; pause = 0; frame_start = 0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_level", 32'(level), 32'(e.lvl));
      chk("sb_lower", 32'(lower_row), 32'(LO + 1 - e.lvl));
      chk("sb_upper", 32'(upper_row), 32'(UP + e.lvl));
      chk("sb_running", 32'(running), 32'(e.run));
      chk("sb_done", 32'(done), 32'(e.dn));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    snap("reset_held", 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    snap("reset", 0, 0, 0);

    // Run: two frames make one step; visible one cycle later
    cycle(1, 0, 0);
    frames(2);
    snap("run_lag", 0, 1, 0);
    cycle(0, 0, 0);
    snap("run_step", 1, 1, 0);

    // Full run from restart
    cycle(1, 0, 0);
    frames(138);
    cycle(0, 0, 0);
    snap("full", 69, 0, 1);
    frames(4);
    cycle(0, 0, 0);
    snap("full_hold", 69, 0, 1);

    // Pause ignores frames and keeps the partial count
    cycle(1, 0, 0);
    frames(1);
    cycle(0, 1, 0);
    frames(5);
    cycle(0, 1, 0);
    frames(1);
    cycle(0, 0, 0);
    snap("pause", 1, 1, 0);

    // start + pause + frame in one cycle: clean restart
    cycle(1, 0, 0);
    frames(1);
    cycle(1, 1, 1);
    snap("coll_a", 0, 1, 0);
    frames(1);
    cycle(0, 0, 0);
    snap("coll_a_cnt0", 0, 1, 0);
    frames(1);
    cycle(0, 0, 0);
    snap("coll_a_step", 1, 1, 0);

    // Final frame plus pause: DONE wins
    cycle(1, 0, 0);
    frames(137);
    cycle(0, 1, 1);
    cycle(0, 0, 0);
    snap("coll_b", 69, 0, 1);

    // Async reset mid-run at level 40
    cycle(1, 0, 0);
    frames(80);
    cycle(0, 0, 0);
    snap("pre_areset", 40, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    snap("areset", 0, 0, 0);
    model_reset();
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    snap("areset_rel", 0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit s, p, f;
      s = ($urandom_range(0, 199) == 0);
      p = ($urandom_range(0, 39) == 0);
      f = ($urandom_range(0, 2) == 0);
      cycle(s, p, f);
    end
    cycle(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
